// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/product handshake bundle for pipelined_tree_multiplier.
// The sgn wire exists only when MULT_SIGNED_EN is defined.
interface pipelined_tree_multiplier_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
`ifdef MULT_SIGNED_EN
   logic               sgn;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] o;

   modport master (
`ifdef MULT_SIGNED_EN
      output sgn,
`endif
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, o
   );

   modport slave (
`ifdef MULT_SIGNED_EN
      input  sgn,
`endif
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, o
   );
endinterface

// File: rtl/pipelined_tree_multiplier.sv
// Two-stage elastic multiplier: carry-save partial-product reduction, then a
// Kogge-Stone prefix adder. Optional macro MULT_SIGNED_EN adds Baugh-Wooley signed mode.
module pipelined_tree_multiplier #(
   parameter int WIDTH = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   pipelined_tree_multiplier_if.slave bus
);
   localparam int PW     = 2 * WIDTH;
   localparam int NR     = WIDTH + 1;
   localparam int LV     = $clog2(PW);
   localparam int STAGES = 2;

   typedef struct packed {
      logic [PW-1:0] sum_row;
      logic [PW-1:0] carry_row;
      logic          sgn;
   } s1_t;

   logic              sgn_in;
   logic [STAGES:1]   vld_pipe;
   logic              ld1, ld2;
   s1_t               s1_d, s1_q;
   logic [PW-1:0]     o_q, o_d;
   logic [NR-1:0][PW-1:0] pp;
   logic [PW-1:0]     csa_s, csa_c, csa_t;
   logic [LV:0][PW-1:0] gk, pk;
   logic              adder_unused;

`ifdef MULT_SIGNED_EN
   assign sgn_in = bus.sgn;
`else
   assign sgn_in = 1'b0;
`endif

   // Row WIDTH carries the 2^WIDTH Baugh-Wooley constant; 2^(2W-1) is applied as an MSB flip in S2.
   always_comb begin
      pp = '0;
      for (int i = 0; i < WIDTH; i++)
         for (int j = 0; j < WIDTH; j++)
            pp[i][i+j] = (bus.x[j] & bus.y[i]) ^
                         (sgn_in & ((i == WIDTH-1) != (j == WIDTH-1)));
      pp[WIDTH][WIDTH] = sgn_in;
   end

   always_comb begin
      csa_t = '0;
      csa_s = pp[0];
      csa_c = pp[1];
      for (int k = 2; k < NR; k++) begin
         csa_t = csa_s ^ csa_c ^ pp[k];
         csa_c = ((csa_s & csa_c) | (csa_s & pp[k]) | (csa_c & pp[k])) << 1;
         csa_s = csa_t;
      end
   end

   assign s1_d.sum_row   = csa_s;
   assign s1_d.carry_row = csa_c;
   assign s1_d.sgn       = sgn_in;

   assign ld2          = ~vld_pipe[2] | bus.out_ready;
   assign ld1          = ~vld_pipe[1] | ld2;
   assign bus.in_ready = ld1;

   assign gk[0] = s1_q.sum_row & s1_q.carry_row;
   assign pk[0] = s1_q.sum_row ^ s1_q.carry_row;

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int D = 1 << l;
      for (genvar i = 0; i < PW; i++) begin : g_bit
         if (i >= D) begin : g_cell
            assign gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-D]);
            assign pk[l+1][i] = pk[l][i] & pk[l][i-D];
         end else begin : g_pass
            assign gk[l+1][i] = gk[l][i];
            assign pk[l+1][i] = pk[l][i];
         end
      end
   end

   // Group propagates beyond the last level and the final carry-out are not needed.
   assign adder_unused = ^{pk, gk[LV][PW-1]};

   always_comb begin
      o_d         = pk[0] ^ {gk[LV][PW-2:0], 1'b0};
      o_d[PW-1]   = o_d[PW-1] ^ s1_q.sgn;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         o_q      <= '0;
      end else begin
         if (ld1) begin
            vld_pipe[1] <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
         end
         if (ld2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) o_q <= o_d;
         end
      end
   end

   assign bus.out_valid = vld_pipe[2];
   assign bus.o         = o_q;
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Bench: WIDTH=8 directed scenarios plus a WIDTH=4 exhaustive sweep, each DUT
// checked every cycle against a queue-based transaction model.
module tb_pipelined_tree_multiplier;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       in_valid = '0;
   logic [1:0]       out_ready = '1;
   logic [1:0]       sgn_d = '0;
   logic [1:0][15:0] xd = '0;
   logic [1:0][15:0] yd = '0;
   logic [1:0]       in_ready_m;
   logic [1:0]       out_valid_m;
   logic [1:0][31:0] o_m;

   int          checks = 0;
   int          errors = 0;
   int          pops1 = 0;
   logic [31:0] log_v[$];
   int          log_c[$];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
      longint sa, sb, p;
      sa = longint'(a) & ((longint'(1) << w) - 1);
      sb = longint'(b) & ((longint'(1) << w) - 1);
      if (s) begin
         if (sa >= (longint'(1) << (w-1))) sa -= (longint'(1) << w);
         if (sb >= (longint'(1) << (w-1))) sb -= (longint'(1) << w);
      end
      p = sa * sb;
      return 32'(p & ((longint'(1) << (2*w)) - 1));
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int W = (g == 0) ? 8 : 4;

      pipelined_tree_multiplier_if #(.WIDTH(W)) bus ();
      pipelined_tree_multiplier #(.WIDTH(W)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      assign bus.in_valid  = in_valid[g];
      assign bus.x         = xd[g][W-1:0];
      assign bus.y         = yd[g][W-1:0];
      assign bus.out_ready = out_ready[g];
`ifdef MULT_SIGNED_EN
      assign bus.sgn       = sgn_d[g];
`endif
      assign in_ready_m[g]  = bus.in_ready;
      assign out_valid_m[g] = bus.out_valid;
      assign o_m[g]         = 32'(bus.o);

      // Model: queue of accepted products; an item is visible one edge after its accept edge.
      logic [31:0] q_p[$];
      int          q_age[$];
      logic [31:0] last_o = '0;
      logic [31:0] nxt;
      int          cyc = 0;
      bit          exp_ov, exp_rdy, acc, cons;

      always begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            q_p.delete();
            q_age.delete();
            last_o = '0;
            chk($sformatf("rst_ready%0d", g), 32'(in_ready_m[g]), 32'd1);
            chk($sformatf("rst_valid%0d", g), 32'(out_valid_m[g]), 32'd0);
            chk($sformatf("rst_o%0d", g), o_m[g], 32'd0);
         end else begin
            exp_ov  = (q_p.size() > 0) && (q_age[0] >= 1);
            exp_rdy = (q_p.size() < 2) || out_ready[g];
            chk($sformatf("in_ready%0d", g), 32'(in_ready_m[g]), 32'(exp_rdy));
            chk($sformatf("out_valid%0d", g), 32'(out_valid_m[g]), 32'(exp_ov));
            chk($sformatf("o%0d", g), o_m[g], exp_ov ? q_p[0] : last_o);
            if (g == 0 && out_valid_m[g] && out_ready[g]) begin
               log_v.push_back(o_m[g]);
               log_c.push_back(cyc);
            end
            acc  = in_valid[g] && exp_rdy;
            cons = exp_ov && out_ready[g];
            nxt  = ref_prod(W, xd[g], yd[g], sgn_d[g]);
            @(posedge clk);
            if (rst_n) begin
               if (cons) begin
                  last_o = q_p.pop_front();
                  void'(q_age.pop_front());
                  if (g == 1) pops1++;
               end
               foreach (q_age[k]) q_age[k]++;
               if (acc) begin
                  q_p.push_back(nxt);
                  q_age.push_back(0);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int g, input logic [15:0] a, input logic [15:0] b,
                        input logic s, output bit acc);
      in_valid[g] = 1'b1;
      xd[g] = a;
      yd[g] = b;
      sgn_d[g] = s;
      #1;
      acc = in_ready_m[g];
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
      sgn_d[g] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n0, n1, guard;
      logic [15:0] s27x [4] = '{16'h00, 16'h01, 16'h80, 16'h0F};
      logic [15:0] s27y [4] = '{16'h37, 16'hFF, 16'h02, 16'h0F};
      logic [31:0] s27o [4] = '{32'h0000, 32'h00FF, 32'h0100, 32'h00E1};

      #3;
      chk("reset_in_ready", 32'(in_ready_m[0]), 32'd1);
      chk("reset_out_valid", 32'(out_valid_m[0]), 32'd0);
      chk("reset_o", o_m[0], 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Operands presented after edge N: valid after N+2, gone after N+3.
      offer(0, 16'hFF, 16'hFF, 1'b0, acc);
      chk("lat_accept", 32'(acc), 32'd1);
      chk("lat_edge1_valid", 32'(out_valid_m[0]), 32'd0);
      step();
      chk("lat_edge2_valid", 32'(out_valid_m[0]), 32'd1);
      chk("lat_edge2_o", o_m[0], 32'hFE01);
      step();
      chk("lat_edge3_valid", 32'(out_valid_m[0]), 32'd0);
      chk("lat_edge3_o_held", o_m[0], 32'hFE01);

      n0 = log_v.size();
      for (int k = 0; k < 4; k++) offer(0, s27x[k], s27y[k], 1'b0, acc);
      repeat (3) step();
      chk("stream_count", 32'(log_v.size() - n0), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (n0 + k < log_v.size()) begin
            chk($sformatf("stream_o%0d", k), log_v[n0+k], s27o[k]);
            chk($sformatf("stream_cycle%0d", k), 32'(log_c[n0+k] - log_c[n0]), 32'(k));
         end
      end

      n0 = log_v.size();
      out_ready[0] = 1'b0;
      offer(0, 16'd3, 16'd5, 1'b0, acc);
      chk("bp_acc0", 32'(acc), 32'd1);
      offer(0, 16'd200, 16'd100, 1'b0, acc);
      chk("bp_acc1", 32'(acc), 32'd1);
      in_valid[0] = 1'b1;
      xd[0] = 16'd17;
      yd[0] = 16'd13;
      #1;
      chk("bp_ready_low", 32'(in_ready_m[0]), 32'd0);
      repeat (2) begin
         step();
         chk("bp_hold_valid", 32'(out_valid_m[0]), 32'd1);
         chk("bp_hold_o", o_m[0], 32'd15);
      end
      out_ready[0] = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 20) begin
         #1;
         acc = in_ready_m[0];
         step();
         guard++;
      end
      chk("bp_third_accept", 32'(acc), 32'd1);
      in_valid[0] = 1'b0;
      repeat (4) step();
      chk("bp_count", 32'(log_v.size() - n0), 32'd3);
      if (log_v.size() - n0 == 3) begin
         chk("bp_out0", log_v[n0], 32'd15);
         chk("bp_out1", log_v[n0+1], 32'h4E20);
         chk("bp_out2", log_v[n0+2], 32'd221);
      end

      offer(0, 16'd9, 16'd9, 1'b0, acc);
      offer(0, 16'd7, 16'd6, 1'b0, acc);
      #1 rst_n = 1'b0;
      n1 = log_v.size();
      #1;
      chk("midrst_valid", 32'(out_valid_m[0]), 32'd0);
      chk("midrst_o", o_m[0], 32'd0);
      chk("midrst_ready", 32'(in_ready_m[0]), 32'd1);
      step();
      step();
      rst_n = 1'b1;
      repeat (5) step();
      chk("midrst_no_stale", 32'(log_v.size()), 32'(n1));
      chk("midrst_idle_valid", 32'(out_valid_m[0]), 32'd0);

`ifdef MULT_SIGNED_EN
      n0 = log_v.size();
      offer(0, 16'h80, 16'h80, 1'b1, acc);
      offer(0, 16'hFF, 16'h01, 1'b1, acc);
      offer(0, 16'h7F, 16'h80, 1'b1, acc);
      offer(0, 16'hFF, 16'h01, 1'b0, acc);
      repeat (3) step();
      chk("sgn_count", 32'(log_v.size() - n0), 32'd4);
      if (log_v.size() - n0 == 4) begin
         chk("sgn_80x80", log_v[n0], 32'h4000);
         chk("sgn_FFx01", log_v[n0+1], 32'hFFFF);
         chk("sgn_7Fx80", log_v[n0+2], 32'hC080);
         chk("uns_FFx01", log_v[n0+3], 32'h00FF);
      end
`endif

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            in_valid[1] = 1'b1;
            xd[1] = 16'(a);
            yd[1] = 16'(b);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 100) begin
               out_ready[1] = 1'($urandom_range(0, 1));
               #1;
               acc = in_ready_m[1];
               step();
               guard++;
            end
            chk("sweep_accept", 32'(acc), 32'd1);
         end
      end
      in_valid[1] = 1'b0;
      out_ready[1] = 1'b1;
      repeat (4) step();
      chk("sweep_count", 32'(pops1), 32'd256);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
